// File: rtl/blu_ntt_sched.sv
// Butterfly sequencer for a single BLU: walks every stage of an in-place N-point NTT/INTT,
// issuing one butterfly per cycle and delaying the write-back addresses to line up with the BLU.
module blu_ntt_sched #(
   parameter int unsigned N       = 16,
   parameter int unsigned MEM_LAT = 1,
   localparam int unsigned LOG_N  = $clog2(N),
   localparam int unsigned L      = MEM_LAT + 2
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic             hold_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [LOG_N-1:0] stage_o,
   output logic             rd_en_o,
   output logic [LOG_N-1:0] rd_addr_a_o,
   output logic [LOG_N-1:0] rd_addr_b_o,
   output logic [LOG_N-1:0] tw_idx_o,
   output logic             ct_o,
   output logic             wr_en_o,
   output logic [LOG_N-1:0] wr_addr_a_o,
   output logic [LOG_N-1:0] wr_addr_b_o
);

   localparam int unsigned CNT_W = $clog2(L + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e           state_q;
   logic             busy_q, done_q, ct_q;
   logic [LOG_N-1:0] stage_q, j_q;
   logic [CNT_W-1:0] cnt_q;

   logic             rd_en;
   logic [LOG_N-1:0] sh, len, grp, off, addr_a, addr_b, tw;

   assign rd_en = (state_q == StIssue) && !hold_i;

   // len is always a power of two, so divide/modulo reduce to shift/mask on log2(len).
   always_comb begin
      sh     = ct_q ? (LOG_N'(LOG_N - 1) - stage_q) : stage_q;
      len    = LOG_N'(1) << sh;
      grp    = j_q >> sh;
      off    = j_q & (len - LOG_N'(1));
      addr_a = ((grp << sh) << 1) | off;
      addr_b = addr_a + len;
      tw     = (LOG_N'(1) << (LOG_N'(LOG_N - 1) - sh)) + grp;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ct_q    <= 1'b0;
         stage_q <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q <= StIssue;
                  busy_q  <= 1'b1;
                  ct_q    <= mode_i;
                  stage_q <= '0;
                  j_q     <= '0;
               end
            end
            StIssue: begin
               if (!hold_i) begin
                  if (j_q == LOG_N'(N / 2 - 1)) begin
                     j_q     <= '0;
                     cnt_q   <= '0;
                     state_q <= StDrain;
                  end else begin
                     j_q <= j_q + LOG_N'(1);
                  end
               end
            end
            StDrain: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(L - 1)) begin
                  if (stage_q == LOG_N'(LOG_N - 1)) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     stage_q <= stage_q + LOG_N'(1);
                     state_q <= StIssue;
                  end
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Write-back delay line: the valid bit and both addresses travel together for L cycles.
   logic [L-1:0]     wv_q;
   logic [LOG_N-1:0] wa_q [L];
   logic [LOG_N-1:0] wb_q [L];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wv_q <= '0;
         for (int i = 0; i < int'(L); i++) begin
            wa_q[i] <= '0;
            wb_q[i] <= '0;
         end
      end else begin
         wv_q    <= {wv_q[L-2:0], rd_en};
         wa_q[0] <= rd_en ? addr_a : '0;
         wb_q[0] <= rd_en ? addr_b : '0;
         for (int i = 1; i < int'(L); i++) begin
            wa_q[i] <= wa_q[i-1];
            wb_q[i] <= wb_q[i-1];
         end
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign stage_o     = stage_q;
   assign ct_o        = ct_q;
   assign rd_en_o     = rd_en;
   assign rd_addr_a_o = rd_en ? addr_a : '0;
   assign rd_addr_b_o = rd_en ? addr_b : '0;
   assign tw_idx_o    = rd_en ? tw : '0;
   assign wr_en_o     = wv_q[L-1];
   assign wr_addr_a_o = wa_q[L-1];
   assign wr_addr_b_o = wb_q[L-1];

endmodule

// File: tb/tb_blu_ntt_sched.sv
// Randomized bench for blu_ntt_sched: a cycle-level job model built from the butterfly
// index formulas predicts every read, write-back, busy and done cycle.
module tb_blu_ntt_sched;

   localparam int N     = 16;
   localparam int LOG_N = 4;
   localparam int L     = 3;
   localparam int HALF  = N / 2;
   localparam int TOTAL = LOG_N * HALF;

   logic             clk_i = 1'b0;
   logic             rstn_i, start_i, mode_i, hold_i;
   logic             busy_o, done_o, rd_en_o, ct_o, wr_en_o;
   logic [LOG_N-1:0] stage_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o, wr_addr_a_o, wr_addr_b_o;

   blu_ntt_sched #(.N(N), .MEM_LAT(1)) u_dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .hold_i      (hold_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .stage_o     (stage_o),
      .rd_en_o     (rd_en_o),
      .rd_addr_a_o (rd_addr_a_o),
      .rd_addr_b_o (rd_addr_b_o),
      .tw_idx_o    (tw_idx_o),
      .ct_o        (ct_o),
      .wr_en_o     (wr_en_o),
      .wr_addr_a_o (wr_addr_a_o),
      .wr_addr_b_o (wr_addr_b_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {int due; int a; int b;} wr_t;
   wr_t wq[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void bfly(input bit fwd, input int s, input int j,
                                output int a, output int b, output int tw);
      int len, grp, off;
      len = fwd ? (N >> (s + 1)) : (1 << s);
      grp = j / len;
      off = j % len;
      a   = 2 * len * grp + off;
      b   = a + len;
      tw  = N / (2 * len) + grp;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_stage"}, stage_o, 0);
      chk({tag, "_rd_en"}, rd_en_o, 0);
      chk({tag, "_rd_a"}, rd_addr_a_o, 0);
      chk({tag, "_rd_b"}, rd_addr_b_o, 0);
      chk({tag, "_tw"}, tw_idx_o, 0);
      chk({tag, "_ct"}, ct_o, 0);
      chk({tag, "_wr_en"}, wr_en_o, 0);
      chk({tag, "_wr_a"}, wr_addr_a_o, 0);
      chk({tag, "_wr_b"}, wr_addr_b_o, 0);
   endtask

   // hold_kind: 0 none, 1 random, 2 five-cycle burst inside stage 0
   task automatic run_job(input bit fwd, input int hold_kind, input bit rand_start,
                          input int abort_k, output int busy_cyc, output int done_cyc,
                          output int eff_holds);
      int k, gap, cyc, a, b, tw;
      bit fin, exp_rd, exp_busy, exp_done, exp_wr;
      k = 0; gap = 0; cyc = 0; fin = 0;
      busy_cyc = 0; done_cyc = -1; eff_holds = 0;
      wq.delete();
      @(posedge clk_i); #1;
      start_i = 1'b1; mode_i = fwd; hold_i = 1'b0;
      while (!fin && cyc < 2000) begin
         @(posedge clk_i); #1;
         cyc++;
         start_i = rand_start ? ($urandom_range(0, 7) == 0) : 1'b0;
         if (rand_start) mode_i = 1'($urandom_range(0, 1));
         case (hold_kind)
            1:       hold_i = ($urandom_range(0, 3) == 0);
            2:       hold_i = (cyc >= 3 && cyc < 8);
            default: hold_i = 1'b0;
         endcase
         @(negedge clk_i);
         exp_rd = 0; exp_busy = 0; exp_done = 0;
         if (gap > 0) begin
            exp_busy = 1;
            gap--;
         end else if (k < TOTAL) begin
            exp_busy = 1;
            if (hold_i) eff_holds++;
            else exp_rd = 1;
         end else begin
            exp_done = 1;
            fin = 1;
         end
         if (busy_o) busy_cyc++;
         if (done_o) done_cyc = cyc;
         chk("rd_en", rd_en_o, exp_rd);
         chk("busy", busy_o, exp_busy);
         chk("done", done_o, exp_done);
         chk("ct", ct_o, fwd);
         if (exp_rd) begin
            bfly(fwd, k / HALF, k % HALF, a, b, tw);
            chk("rd_a", rd_addr_a_o, a);
            chk("rd_b", rd_addr_b_o, b);
            chk("tw", tw_idx_o, tw);
            chk("stage", stage_o, k / HALF);
            wq.push_back('{cyc + L, a, b});
            k++;
            if (k % HALF == 0) gap = L;
         end
         exp_wr = (wq.size() > 0) && (wq[0].due == cyc);
         chk("wr_en", wr_en_o, exp_wr);
         if (exp_wr) begin
            chk("wr_a", wr_addr_a_o, wq[0].a);
            chk("wr_b", wr_addr_b_o, wq[0].b);
            void'(wq.pop_front());
         end
         if (abort_k >= 0 && k == abort_k) begin
            start_i = 1'b0; hold_i = 1'b0;
            return;
         end
      end
      if (!fin) chk("job_timeout", 0, 1);
      start_i = 1'b0; hold_i = 1'b0;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_rd_en", rd_en_o, 0);
      chk("idle_wr_en", wr_en_o, 0);
   endtask

   initial begin
      int bc, dc, hc;
      bit m;
      rstn_i = 1'b0; start_i = 1'b0; mode_i = 1'b0; hold_i = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk_i);
      rstn_i = 1'b1;

      run_job(1'b1, 0, 1'b0, -1, bc, dc, hc);
      chk("fwd_busy_cycles", bc, 44);
      chk("fwd_done_cycle", dc, 45);

      run_job(1'b0, 0, 1'b0, -1, bc, dc, hc);
      chk("inv_busy_cycles", bc, 44);
      chk("inv_done_cycle", dc, 45);

      run_job(1'b1, 2, 1'b0, -1, bc, dc, hc);
      chk("hold_busy_cycles", bc, 49);
      chk("hold_done_cycle", dc, 50);

      for (int r = 0; r < 6; r++) begin
         m = 1'($urandom_range(0, 1));
         run_job(m, 1, 1'b1, -1, bc, dc, hc);
         chk("rand_busy_cycles", bc, LOG_N * (HALF + L) + hc);
         chk("rand_done_cycle", dc, bc + 1);
      end

      // Abort in the middle of stage 2 and confirm nothing in flight escapes.
      run_job(1'b1, 0, 1'b0, 2 * HALF + 3, bc, dc, hc);
      @(posedge clk_i); #1;
      rstn_i  = 1'b0;
      start_i = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(negedge clk_i);
      start_i = 1'b0;
      rstn_i  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         chk("post_rst_wr_en", wr_en_o, 0);
         chk("post_rst_busy", busy_o, 0);
      end

      run_job(1'b0, 1, 1'b1, -1, bc, dc, hc);
      chk("final_busy_cycles", bc, LOG_N * (HALF + L) + hc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
